// File: rtl/interconn_tx.sv
// -----------------------------------------------------------------------------
// interconn_tx
//
// Per-MVU transmit engine for one source port of the MVU crossbar. A start
// command latches a job description, then the engine reads cfg_len words from
// local data memory (1-cycle read latency) at src_base + k*src_stride and puts
// them, in order, on the crossbar send bus with remote write addresses
// dst_base + k. A single-entry skid buffer catches the read that is already
// in flight when hold rises, so no word is ever lost or duplicated.
//
// Ports:
//   clk, clr        clock; asynchronous active-high reset
//   start           job start pulse (only looked at while idle)
//   cfg_dest        destination MVU mask (multi-cast allowed)
//   cfg_src_base    first local read address
//   cfg_src_stride  local read address increment per word
//   cfg_dst_base    first remote write address
//   cfg_len         number of words to send (0 completes immediately)
//   hold            stall request; no word is presented while high
//   mem_rd_en/addr  local memory read request
//   mem_rd_data     read data, valid the cycle after mem_rd_en
//   send_to/en/addr/word  crossbar send bus
//   busy            job in progress
//   done            one-cycle completion pulse
//
// Build option:
//   INTERCONN_TX_SELF_MASK_EN  when defined, bit SELF_ID of the latched
//                              destination mask is cleared so this MVU never
//                              addresses itself.
// -----------------------------------------------------------------------------
module interconn_tx #(
    parameter int N       = 8,
    parameter int W       = 64,
    parameter int BADDR   = 15,
    parameter int LADDR   = 15,
    parameter int LENW    = 16,
    parameter int SELF_ID = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [N-1:0]     cfg_dest,
    input  logic [LADDR-1:0] cfg_src_base,
    input  logic [LADDR-1:0] cfg_src_stride,
    input  logic [BADDR-1:0] cfg_dst_base,
    input  logic [LENW-1:0]  cfg_len,
    input  logic             hold,
    output logic             mem_rd_en,
    output logic [LADDR-1:0] mem_rd_addr,
    input  logic [W-1:0]     mem_rd_data,
    output logic [N-1:0]     send_to,
    output logic             send_en,
    output logic [BADDR-1:0] send_addr,
    output logic [W-1:0]     send_word,
    output logic             busy,
    output logic             done
);

    localparam logic [N-1:0] SELF_BIT = {{(N-1){1'b0}}, 1'b1} << SELF_ID;

`ifdef INTERCONN_TX_SELF_MASK_EN
    localparam logic [N-1:0] DEST_KEEP = ~SELF_BIT;
`else
    // All ones: the destination mask passes through untouched.
    localparam logic [N-1:0] DEST_KEEP = SELF_BIT | ~SELF_BIT;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [N-1:0]     dest_q,      dest_d;
    logic [LADDR-1:0] stride_q,    stride_d;
    logic [LADDR-1:0] rd_addr_q,   rd_addr_d;
    logic [LENW-1:0]  rd_rem_q,    rd_rem_d;
    logic [LENW-1:0]  pres_rem_q,  pres_rem_d;
    logic [BADDR-1:0] nxt_addr_q,  nxt_addr_d;
    logic             rd_vld_q,    rd_vld_d;
    logic             skid_full_q, skid_full_d;
    logic [W-1:0]     skid_data_q, skid_data_d;
    logic             send_en_q,   send_en_d;
    logic [N-1:0]     send_to_q,   send_to_d;
    logic [BADDR-1:0] send_addr_q, send_addr_d;
    logic [W-1:0]     send_word_q, send_word_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;

    logic rd_en;
    logic present_skid;
    logic present_mem;
    logic to_skid;

    always_comb begin
        // A read is only issued when the skid buffer is empty, so a word caught
        // by hold always has somewhere to go.
        rd_en        = (state_q == S_RUN) && (rd_rem_q != '0) && !hold && !skid_full_q;
        // Skid data is older than anything returning from memory, so it wins.
        present_skid = !hold && skid_full_q;
        present_mem  = !hold && !skid_full_q && rd_vld_q;
        to_skid      = hold && rd_vld_q;

        state_d     = state_q;
        dest_d      = dest_q;
        stride_d    = stride_q;
        rd_addr_d   = rd_addr_q;
        rd_rem_d    = rd_rem_q;
        pres_rem_d  = pres_rem_q;
        nxt_addr_d  = nxt_addr_q;
        rd_vld_d    = rd_en;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        send_en_d   = 1'b0;
        send_addr_d = send_addr_q;
        send_word_d = send_word_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        state_d    = S_RUN;
                        dest_d     = cfg_dest & DEST_KEEP;
                        stride_d   = cfg_src_stride;
                        rd_addr_d  = cfg_src_base;
                        rd_rem_d   = cfg_len;
                        pres_rem_d = cfg_len;
                        nxt_addr_d = cfg_dst_base;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (rd_en) begin
                    rd_addr_d = rd_addr_q + stride_q;
                    rd_rem_d  = rd_rem_q - LENW'(1);
                end
                // The last word is on the bus this cycle once nothing is left
                // to present.
                if (send_en_q && (pres_rem_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (present_skid || present_mem) begin
            send_en_d   = 1'b1;
            send_word_d = present_skid ? skid_data_q : mem_rd_data;
            send_addr_d = nxt_addr_q;
            nxt_addr_d  = nxt_addr_q + BADDR'(1);
            pres_rem_d  = pres_rem_q - LENW'(1);
        end
        if (present_skid) begin
            skid_full_d = 1'b0;
        end
        if (to_skid) begin
            skid_full_d = 1'b1;
            skid_data_d = mem_rd_data;
        end

        // dest_d already holds the freshly latched mask on the IDLE->RUN edge.
        send_to_d = (state_d == S_RUN) ? dest_d : '0;
        busy_d    = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= S_IDLE;
            dest_q      <= '0;
            stride_q    <= '0;
            rd_addr_q   <= '0;
            rd_rem_q    <= '0;
            pres_rem_q  <= '0;
            nxt_addr_q  <= '0;
            rd_vld_q    <= 1'b0;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            send_en_q   <= 1'b0;
            send_to_q   <= '0;
            send_addr_q <= '0;
            send_word_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            stride_q    <= stride_d;
            rd_addr_q   <= rd_addr_d;
            rd_rem_q    <= rd_rem_d;
            pres_rem_q  <= pres_rem_d;
            nxt_addr_q  <= nxt_addr_d;
            rd_vld_q    <= rd_vld_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            send_en_q   <= send_en_d;
            send_to_q   <= send_to_d;
            send_addr_q <= send_addr_d;
            send_word_q <= send_word_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_rd_en   = rd_en;
    assign mem_rd_addr = rd_addr_q;
    assign send_to     = send_to_q;
    assign send_en     = send_en_q;
    assign send_addr   = send_addr_q;
    assign send_word   = send_word_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_interconn_tx.sv
// -----------------------------------------------------------------------------
// tb_interconn_tx
//
// Directed bench for interconn_tx. Each job pushes its expected read addresses
// and expected send beats into queues; a monitor pops and compares whenever
// the DUT drives mem_rd_en or send_en, and records timing of reads, sends,
// busy and done for the per-job checks.
// -----------------------------------------------------------------------------
module tb_interconn_tx;

    localparam int N = 8, W = 64, BADDR = 15, LADDR = 15, LENW = 16;

    logic             clk;
    logic             clr;
    logic             start;
    logic [N-1:0]     cfg_dest;
    logic [LADDR-1:0] cfg_src_base;
    logic [LADDR-1:0] cfg_src_stride;
    logic [BADDR-1:0] cfg_dst_base;
    logic [LENW-1:0]  cfg_len;
    logic             hold;
    logic             mem_rd_en;
    logic [LADDR-1:0] mem_rd_addr;
    logic [W-1:0]     mem_rd_data;
    logic [N-1:0]     send_to;
    logic             send_en;
    logic [BADDR-1:0] send_addr;
    logic [W-1:0]     send_word;
    logic             busy;
    logic             done;

    interconn_tx #(
        .N(N), .W(W), .BADDR(BADDR), .LADDR(LADDR), .LENW(LENW), .SELF_ID(2)
    ) dut (
        .clk(clk), .clr(clr), .start(start),
        .cfg_dest(cfg_dest), .cfg_src_base(cfg_src_base),
        .cfg_src_stride(cfg_src_stride), .cfg_dst_base(cfg_dst_base),
        .cfg_len(cfg_len), .hold(hold),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .send_to(send_to), .send_en(send_en), .send_addr(send_addr),
        .send_word(send_word), .busy(busy), .done(done)
    );

    typedef struct {
        logic [BADDR-1:0] addr;
        logic [W-1:0]     word;
        logic [N-1:0]     to;
    } snd_t;

    snd_t             exp_q[$];
    logic [LADDR-1:0] rd_q[$];

    int n_pass = 0;
    int n_total = 0;

    int cyc_abs = 0;
    int t0 = 0;
    int mon_rel;
    int n_reads, first_rd, last_rd;
    int n_sends, first_send, last_send;
    int n_busy, first_busy;
    int n_done, done_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_abs <= cyc_abs + 1;

    function automatic logic [W-1:0] data_of(input logic [LADDR-1:0] a);
        logic [W-1:0] x;
        x = {{(W-LADDR){1'b0}}, a};
        return 64'hD00D_0000_0000_0000 | x | (x << 32);
    endfunction

    // SELF_ID is 2 in this bench.
    function automatic logic [N-1:0] exp_to(input logic [N-1:0] d);
`ifdef INTERCONN_TX_SELF_MASK_EN
        return d & 8'b1111_1011;
`else
        return d;
`endif
    endfunction

    // Local memory model with 1-cycle read latency.
    initial mem_rd_data = '0;
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= data_of(mem_rd_addr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        mon_rel = cyc_abs - t0;
        if (mem_rd_en) begin
            n_reads++;
            if (n_reads == 1) first_rd = mon_rel;
            last_rd = mon_rel;
            if (rd_q.size() == 0) check("rd_unexpected", 64'(1), 64'(0));
            else check("rd_addr", 64'(mem_rd_addr), 64'(rd_q.pop_front()));
        end
        if (send_en) begin
            n_sends++;
            if (n_sends == 1) first_send = mon_rel;
            last_send = mon_rel;
            if (exp_q.size() == 0) check("send_unexpected", 64'(1), 64'(0));
            else begin
                snd_t e;
                e = exp_q.pop_front();
                check("send_addr", 64'(send_addr), 64'(e.addr));
                check("send_word", send_word, e.word);
                check("send_to", 64'(send_to), 64'(e.to));
            end
        end
        if (busy) begin
            n_busy++;
            if (n_busy == 1) first_busy = mon_rel;
        end
        if (done) begin
            n_done++;
            done_cyc = mon_rel;
            check("done_busy_low", 64'(busy), 64'(0));
            check("done_send_en_low", 64'(send_en), 64'(0));
            check("done_send_to_zero", 64'(send_to), 64'(0));
        end
    end

    task automatic clear_stats();
        n_reads = 0; first_rd = -1; last_rd = -1;
        n_sends = 0; first_send = -1; last_send = -1;
        n_busy = 0; first_busy = -1;
        n_done = 0; done_cyc = -1;
    endtask

    task automatic push_rd(input logic [LADDR-1:0] a);
        rd_q.push_back(a);
    endtask

    task automatic push_snd(input logic [BADDR-1:0] a, input logic [LADDR-1:0] ra,
                            input logic [N-1:0] d);
        snd_t e;
        e.addr = a;
        e.word = data_of(ra);
        e.to   = exp_to(d);
        exp_q.push_back(e);
    endtask

    // Start pulse in relative cycle 0; hold high in cycles hlo..hhi; optional
    // second start in cycle restart_at. Returns three idle cycles after done.
    task automatic run_job(input logic [N-1:0] dest, input logic [LADDR-1:0] src,
                           input logic [LADDR-1:0] stride, input logic [BADDR-1:0] dst,
                           input logic [LENW-1:0] len, input int hlo, input int hhi,
                           input int restart_at);
        @(posedge clk); #1;
        clear_stats();
        t0 = cyc_abs;
        cfg_dest = dest; cfg_src_base = src; cfg_src_stride = stride;
        cfg_dst_base = dst; cfg_len = len;
        start = 1'b1; hold = 1'b0;
        for (int i = 1; i < 200; i++) begin
            @(posedge clk); #1;
            start = (i == restart_at);
            hold  = (i >= hlo) && (i <= hhi);
            if (n_done > 0 && i >= done_cyc + 3) break;
        end
        start = 1'b0; hold = 1'b0;
        if (n_done == 0) check("job_timeout", 64'(0), 64'(1));
        check("rd_queue_drained", 64'(rd_q.size()), 64'(0));
        check("send_queue_drained", 64'(exp_q.size()), 64'(0));
        rd_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_rd_en"}, 64'(mem_rd_en), 64'(0));
        check({tag, "_mem_rd_addr"}, 64'(mem_rd_addr), 64'(0));
        check({tag, "_send_to"}, 64'(send_to), 64'(0));
        check({tag, "_send_en"}, 64'(send_en), 64'(0));
        check({tag, "_send_addr"}, 64'(send_addr), 64'(0));
        check({tag, "_send_word"}, send_word, 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; start = 1'b0; hold = 1'b0;
        cfg_dest = '0; cfg_src_base = '0; cfg_src_stride = '0;
        cfg_dst_base = '0; cfg_len = '0;
        clear_stats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (2) @(posedge clk);

        // Basic transfer.
        push_rd(15'h10); push_rd(15'h11); push_rd(15'h12); push_rd(15'h13);
        push_snd(15'h100, 15'h10, 8'b0000_0100);
        push_snd(15'h101, 15'h11, 8'b0000_0100);
        push_snd(15'h102, 15'h12, 8'b0000_0100);
        push_snd(15'h103, 15'h13, 8'b0000_0100);
        run_job(8'b0000_0100, 15'h10, 15'h1, 15'h100, 16'd4, 0, -1, -1);
        check("basic_first_rd", 64'(first_rd), 64'(1));
        check("basic_last_rd", 64'(last_rd), 64'(4));
        check("basic_first_send", 64'(first_send), 64'(3));
        check("basic_last_send", 64'(last_send), 64'(6));
        check("basic_n_sends", 64'(n_sends), 64'(4));
        check("basic_done_cyc", 64'(done_cyc), 64'(7));
        check("basic_n_done", 64'(n_done), 64'(1));
        check("basic_first_busy", 64'(first_busy), 64'(1));
        check("basic_n_busy", 64'(n_busy), 64'(6));

        // Stride and address wrap.
        push_rd(15'h7FFE); push_rd(15'h0001); push_rd(15'h0004);
        push_snd(15'h7FFF, 15'h7FFE, 8'b1000_0001);
        push_snd(15'h0000, 15'h0001, 8'b1000_0001);
        push_snd(15'h0001, 15'h0004, 8'b1000_0001);
        run_job(8'b1000_0001, 15'h7FFE, 15'h3, 15'h7FFF, 16'd3, 0, -1, -1);
        check("wrap_n_reads", 64'(n_reads), 64'(3));
        check("wrap_n_sends", 64'(n_sends), 64'(3));
        check("wrap_done_cyc", 64'(done_cyc), 64'(6));

        // Stall and skid: hold high in cycles 4..6.
        push_rd(15'h20); push_rd(15'h22); push_rd(15'h24);
        push_rd(15'h26); push_rd(15'h28); push_rd(15'h2A);
        push_snd(15'h200, 15'h20, 8'h30); push_snd(15'h201, 15'h22, 8'h30);
        push_snd(15'h202, 15'h24, 8'h30); push_snd(15'h203, 15'h26, 8'h30);
        push_snd(15'h204, 15'h28, 8'h30); push_snd(15'h205, 15'h2A, 8'h30);
        run_job(8'h30, 15'h20, 15'h2, 15'h200, 16'd6, 4, 6, -1);
        check("stall_n_reads", 64'(n_reads), 64'(6));
        check("stall_n_sends", 64'(n_sends), 64'(6));
        check("stall_last_send_by_12", 64'(last_send <= 12), 64'(1));
        check("stall_done_after_last", 64'(done_cyc), 64'(last_send + 1));
        check("stall_n_done", 64'(n_done), 64'(1));

        // Zero length.
        run_job(8'hFF, 15'h0, 15'h1, 15'h0, 16'd0, 0, -1, -1);
        check("zero_done_cyc", 64'(done_cyc), 64'(1));
        check("zero_n_reads", 64'(n_reads), 64'(0));
        check("zero_n_sends", 64'(n_sends), 64'(0));
        check("zero_n_busy", 64'(n_busy), 64'(0));

        // Start while busy is ignored.
        for (int k = 0; k < 5; k++) begin
            push_rd(15'(15'h50 + k));
            push_snd(15'(15'h50 + k), 15'(15'h50 + k), 8'h01);
        end
        run_job(8'h01, 15'h50, 15'h1, 15'h50, 16'd5, 0, -1, 3);
        check("busy_start_n_sends", 64'(n_sends), 64'(5));
        check("busy_start_n_reads", 64'(n_reads), 64'(5));
        check("busy_start_n_done", 64'(n_done), 64'(1));
        check("busy_start_done_cyc", 64'(done_cyc), 64'(8));

        // Self mask: SELF_ID=2, dest 0000_0110.
        push_rd(15'h60); push_rd(15'h61);
        push_snd(15'h10, 15'h60, 8'b0000_0110);
        push_snd(15'h11, 15'h61, 8'b0000_0110);
        run_job(8'b0000_0110, 15'h60, 15'h1, 15'h10, 16'd2, 0, -1, -1);
        check("self_n_sends", 64'(n_sends), 64'(2));

        // Reset mid-run: clr while word 2 of 8 is on the bus (cycle 5).
        @(posedge clk); #1;
        clear_stats();
        for (int k = 0; k < 5; k++) push_rd(15'(15'h40 + k));
        for (int k = 0; k < 3; k++) push_snd(15'(15'h300 + k), 15'(15'h40 + k), 8'h80);
        t0 = cyc_abs;
        cfg_dest = 8'h80; cfg_src_base = 15'h40; cfg_src_stride = 15'h1;
        cfg_dst_base = 15'h300; cfg_len = 16'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check_outputs_zero("abort");
        repeat (4) @(posedge clk);
        #1;
        check("abort_n_done", 64'(n_done), 64'(0));
        check("abort_n_sends", 64'(n_sends), 64'(3));
        check("abort_n_reads", 64'(n_reads), 64'(5));
        check("abort_rd_queue", 64'(rd_q.size()), 64'(0));
        check("abort_send_queue", 64'(exp_q.size()), 64'(0));
        rd_q.delete();
        exp_q.delete();

        // Normal transfer after the abort.
        push_rd(15'h70); push_rd(15'h71);
        push_snd(15'h400, 15'h70, 8'h08);
        push_snd(15'h401, 15'h71, 8'h08);
        run_job(8'h08, 15'h70, 15'h1, 15'h400, 16'd2, 0, -1, -1);
        check("post_abort_n_sends", 64'(n_sends), 64'(2));
        check("post_abort_done_cyc", 64'(done_cyc), 64'(5));
        check("post_abort_first_send", 64'(first_send), 64'(3));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/interconn_tx.md
Name: interconn_tx

Overview:
- Per-MVU transmit engine that feeds one source port of the MVU crossbar interconnect.
- On a start command it reads a block of words from the MVU's local data memory (1-cycle read latency) and drives them, in order, onto the crossbar send bus, together with the destination MVU mask and consecutive remote write addresses.
- A 1-entry skid buffer absorbs the in-flight read when the MVU stalls the transfer.

Parameters:
- N, 8, number of MVUs; width of the destination mask.
- W, 64, data word width.
- BADDR, 15, remote memory address width.
- LADDR, 15, local memory read address width.
- LENW, 16, width of the transfer length field.
- SELF_ID, 0, index of the MVU that owns this instance; used only by the optional feature.

Ports:
- clk  in  1  clock.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  start pulse; sampled only in IDLE.
- cfg_dest  in  N  destination MVU mask (multi-cast allowed).
- cfg_src_base  in  LADDR  first local read address.
- cfg_src_stride  in  LADDR  local address increment per word.
- cfg_dst_base  in  BADDR  first remote write address.
- cfg_len  in  LENW  number of words to send.
- hold  in  1  stall request; while high, no word is presented.
- mem_rd_en  out  1  local memory read strobe.
- mem_rd_addr  out  LADDR  local memory read address.
- mem_rd_data  in  W  read data, valid the cycle after mem_rd_en.
- send_to  out  N  destination mask to the crossbar.
- send_en  out  1  send valid to the crossbar.
- send_addr  out  BADDR  remote write address.
- send_word  out  W  data word.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: every output is 0. The FSM returns to IDLE, the skid buffer is emptied, and the counters are cleared. clr asserted mid-transfer aborts the job immediately, with no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN: start=1 and cfg_len≠0. On this transition cfg_* are latched and busy goes high in the next cycle.
  - IDLE→DONE: start=1 and cfg_len=0. No reads and no sends occur.
  - RUN→DONE: the cycle in which the last word has send_en=1.
  - DONE→IDLE: unconditionally after one cycle. done=1 only while in DONE, and busy=0 in DONE.
  - start while busy is ignored.
- Read issue, in cycle t: allowed when state=RUN, reads remaining>0, hold=0 and the skid buffer is empty.
  - mem_rd_addr = src_base + k*src_stride for word k, modulo 2^LADDR.
- Data placement, at the clock edge ending the cycle in which data or a skid word is available:
  - hold=0, skid full: present the skid word; the skid buffer empties.
  - hold=0, skid empty, mem data valid: present the mem data.
  - hold=1, mem data valid: the mem data goes into the skid buffer.
  - No word presented: send_en<=0.
- Skid overflow cannot occur, because no read is issued while the skid buffer is full.
- Presented word k:
  - send_en=1.
  - send_word = data for word k.
  - send_addr = dst_base + k, modulo 2^BADDR.
  - send_to = latched cfg_dest.
- Outside RUN, send_to=0 and send_en=0. send_addr and send_word keep their last values when send_en=0.
- Nominal latency with hold=0 (start high in cycle 0):
  - mem_rd_en high in cycles 1..len.
  - send_en high in cycles 3..len+2, with word k in cycle 3+k.
  - done in cycle len+3.
  - busy high in cycles 1..len+2.
- hold effects:
  - hold asserted for H cycles during RUN removes exactly H presentation slots, plus at most one extra bubble when the skid buffer drains.
  - Word order and count are preserved: exactly cfg_len words are sent, and no word is duplicated or dropped.
- The interconnect gives no backpressure. Words lost to arbitration are the software's responsibility.

Optional Feature:
- Macro INTERCONN_TX_SELF_MASK_EN.
  - Defined: send_to = latched cfg_dest with bit SELF_ID forced to 0.
  - Defined, and the masked value is all-zero: the transfer still runs (reads, send_en, done), but no destination is addressed.
  - Not defined: send_to = latched cfg_dest unmodified, so self-send is permitted.

Test Plan:
- Reset mid-run: clr during word 2 of len=8 → all outputs 0 next cycle; no done; a new start afterwards runs a normal transfer.
- Basic transfer: len=4, src_base=0x10, stride=1, dst_base=0x100, dest=8'b0000_0100, hold=0 → mem_rd_addr 0x10..0x13 in cycles 1–4; send_en in cycles 3–6 with send_addr 0x100..0x103 and matching data; done in cycle 7.
- Stride and wrap: LADDR=15, src_base=0x7FFE, stride=3, dst_base=0x7FFF, len=3 → reads at 0x7FFE, 0x0001, 0x0004; send_addr 0x7FFF, 0x0000, 0x0001.
- Stall and skid: len=6; hold high in cycles 4–6 → exactly 6 sends in order, no duplicates, last send in or before cycle 12, done the cycle after the last send.
- Zero length and busy start: cfg_len=0 → done in cycle 1 with no mem_rd_en or send_en; a second start during a len=5 job is ignored (5 sends, one done).
- Self mask: SELF_ID=2, dest=8'b0000_0110, with the macro → send_to=8'b0000_0010; without the macro → 8'b0000_0110.
